// File: rtl/reg_rename_file.sv
// Register file with rename status: per-register value plus ROB tag of the pending
// producer, with same-cycle forwarding from older issue lanes and commit lanes.
module reg_rename_file #(
    parameter int REG_NUM  = 32,
    parameter int REG_W    = 32,
    parameter int ROB_ID_W = 4,
    parameter int N_ISSUE  = 2,
    parameter int N_COMMIT = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 rdy,
    input  logic [N_ISSUE*$clog2(REG_NUM)-1:0]   rs_from_issuer,
    input  logic [N_ISSUE*$clog2(REG_NUM)-1:0]   rt_from_issuer,
    input  logic [N_ISSUE*$clog2(REG_NUM)-1:0]   rd_from_issuer,
    input  logic [N_ISSUE*ROB_ID_W-1:0]          dest_from_issuer,
    output logic [N_ISSUE*REG_W-1:0]             vj_to_issuer,
    output logic [N_ISSUE*REG_W-1:0]             vk_to_issuer,
    output logic [N_ISSUE*ROB_ID_W-1:0]          qj_to_issuer,
    output logic [N_ISSUE*ROB_ID_W-1:0]          qk_to_issuer,
    input  logic [N_COMMIT*$clog2(REG_NUM)-1:0]  rd_from_ro_buffer,
    input  logic [N_COMMIT*ROB_ID_W-1:0]         dest_from_ro_buffer,
    input  logic [N_COMMIT*REG_W-1:0]            value_from_ro_buffer,
    input  logic                                 reset_from_rob_bus,
    output logic [$clog2(REG_NUM):0]             busy_count
);

    localparam int RID_W = $clog2(REG_NUM);
    localparam int CNT_W = RID_W + 1;

    logic [N_ISSUE-1:0][RID_W-1:0]     rs_l, rt_l, rd_l;
    logic [N_ISSUE-1:0][ROB_ID_W-1:0]  dest_l;
    logic [N_COMMIT-1:0][RID_W-1:0]    crd_l;
    logic [N_COMMIT-1:0][ROB_ID_W-1:0] cdest_l;
    logic [N_COMMIT-1:0][REG_W-1:0]    cval_l;

    logic [N_ISSUE-1:0][ROB_ID_W-1:0]  qj_l, qk_l;
    logic [N_ISSUE-1:0][REG_W-1:0]     vj_l, vk_l;

    logic [REG_W-1:0]    values     [REG_NUM];
    logic [ROB_ID_W-1:0] status     [REG_NUM];
    logic [REG_W-1:0]    values_nxt [REG_NUM];
    logic [ROB_ID_W-1:0] status_nxt [REG_NUM];
    logic [CNT_W-1:0]    cnt_nxt;

    assign rs_l    = rs_from_issuer;
    assign rt_l    = rt_from_issuer;
    assign rd_l    = rd_from_issuer;
    assign dest_l  = dest_from_issuer;
    assign crd_l   = rd_from_ro_buffer;
    assign cdest_l = dest_from_ro_buffer;
    assign cval_l  = value_from_ro_buffer;

    assign qj_to_issuer = qj_l;
    assign qk_to_issuer = qk_l;
    assign vj_to_issuer = vj_l;
    assign vk_to_issuer = vk_l;

    // Returns {tag, value}; older issue lanes beat commits, commits beat stored state.
    function automatic logic [ROB_ID_W+REG_W-1:0] lookup(input logic [RID_W-1:0] src,
                                                         input int lane);
        logic [ROB_ID_W-1:0] q;
        logic [REG_W-1:0]    v;
        logic                hit;
        q   = '0;
        v   = '0;
        hit = 1'b0;
        if (src != '0) begin
            for (int j = 0; j < N_ISSUE; j++) begin
                if (j < lane && rd_l[j] == src) begin
                    q   = dest_l[j];
                    hit = 1'b1;
                end
            end
            if (!hit) begin
                for (int c = 0; c < N_COMMIT; c++) begin
                    if (crd_l[c] == src && status[src] == cdest_l[c]) begin
                        v   = cval_l[c];
                        hit = 1'b1;
                    end
                end
            end
            if (!hit) begin
                if (status[src] != '0) q = status[src];
                else                   v = values[src];
            end
        end
        return {q, v};
    endfunction

    always_comb begin
        for (int i = 0; i < N_ISSUE; i++) begin
            {qj_l[i], vj_l[i]} = lookup(rs_l[i], i);
            {qk_l[i], vk_l[i]} = lookup(rt_l[i], i);
        end
    end

    // Next state: commit writes, then clears, then renames so a rename overrides a clear.
    always_comb begin
        values_nxt = values;
        status_nxt = status;
        cnt_nxt    = '0;
        for (int c = 0; c < N_COMMIT; c++) begin
            if (crd_l[c] != '0) values_nxt[crd_l[c]] = cval_l[c];
        end
        if (reset_from_rob_bus) begin
            for (int r = 0; r < REG_NUM; r++) status_nxt[r] = '0;
        end else begin
            for (int c = 0; c < N_COMMIT; c++) begin
                if (crd_l[c] != '0 && status[crd_l[c]] == cdest_l[c])
                    status_nxt[crd_l[c]] = '0;
            end
            for (int i = 0; i < N_ISSUE; i++) begin
                if (rd_l[i] != '0) status_nxt[rd_l[i]] = dest_l[i];
            end
        end
        for (int r = 0; r < REG_NUM; r++) begin
            cnt_nxt = cnt_nxt + CNT_W'(status_nxt[r] != '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < REG_NUM; r++) begin
                values[r] <= '0;
                status[r] <= '0;
            end
            busy_count <= '0;
        end else if (rdy) begin
            values     <= values_nxt;
            status     <= status_nxt;
            busy_count <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_reg_rename_file.sv
// Bench for reg_rename_file: vector table feeding a scoreboard queue, then an
// asynchronous-reset sequence between clock edges.
module tb_reg_rename_file;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic [9:0]  rs_from_issuer, rt_from_issuer, rd_from_issuer;
    logic [7:0]  dest_from_issuer;
    logic [63:0] vj_to_issuer, vk_to_issuer;
    logic [7:0]  qj_to_issuer, qk_to_issuer;
    logic [9:0]  rd_from_ro_buffer;
    logic [7:0]  dest_from_ro_buffer;
    logic [63:0] value_from_ro_buffer;
    logic        reset_from_rob_bus;
    logic [5:0]  busy_count;

    reg_rename_file dut (
        .clk                  (clk),
        .rst                  (rst),
        .rdy                  (rdy),
        .rs_from_issuer       (rs_from_issuer),
        .rt_from_issuer       (rt_from_issuer),
        .rd_from_issuer       (rd_from_issuer),
        .dest_from_issuer     (dest_from_issuer),
        .vj_to_issuer         (vj_to_issuer),
        .vk_to_issuer         (vk_to_issuer),
        .qj_to_issuer         (qj_to_issuer),
        .qk_to_issuer         (qk_to_issuer),
        .rd_from_ro_buffer    (rd_from_ro_buffer),
        .dest_from_ro_buffer  (dest_from_ro_buffer),
        .value_from_ro_buffer (value_from_ro_buffer),
        .reset_from_rob_bus   (reset_from_rob_bus),
        .busy_count           (busy_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             chk;
        logic [1:0][3:0]  qj, qk;
        logic [1:0][31:0] vj, vk;
        logic [5:0]       busy;
    } exp_t;

    typedef struct packed {
        logic             rdy, flush;
        logic [1:0][4:0]  rs, rt, rd;
        logic [1:0][3:0]  dest;
        logic [1:0][4:0]  crd;
        logic [1:0][3:0]  cdest;
        logic [1:0][31:0] cval;
        exp_t             e;
    } vec_t;

    vec_t tbl[$];
    exp_t sb[$];
    vec_t cur;
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic clr();
        cur = '0;
        cur.rdy = 1'b1;
        cur.e.chk = 1'b1;
    endtask

    task automatic iss(input int l, input int rs, input int rt, input int rd, input int d);
        cur.rs[l] = 5'(rs); cur.rt[l] = 5'(rt); cur.rd[l] = 5'(rd); cur.dest[l] = 4'(d);
    endtask

    task automatic cmt(input int l, input int rd, input int d, input logic [31:0] v);
        cur.crd[l] = 5'(rd); cur.cdest[l] = 4'(d); cur.cval[l] = v;
    endtask

    task automatic ex(input int l, input int qj, input logic [31:0] vj,
                      input int qk, input logic [31:0] vk);
        cur.e.qj[l] = 4'(qj); cur.e.vj[l] = vj; cur.e.qk[l] = 4'(qk); cur.e.vk[l] = vk;
    endtask

    task automatic add(input int busy);
        cur.e.busy = 6'(busy);
        tbl.push_back(cur);
        clr();
    endtask

    task automatic drive(input vec_t v);
        rdy = v.rdy; reset_from_rob_bus = v.flush;
        rs_from_issuer = v.rs; rt_from_issuer = v.rt; rd_from_issuer = v.rd;
        dest_from_issuer = v.dest;
        rd_from_ro_buffer = v.crd; dest_from_ro_buffer = v.cdest;
        value_from_ro_buffer = v.cval;
    endtask

    initial begin
        vec_t v;
        exp_t e;

        clr();
        // 0: after reset every lookup is empty
        iss(0, 1, 2, 0, 0); iss(1, 3, 0, 0, 0); ex(0, 0, 0, 0, 0); ex(1, 0, 0, 0, 0); add(0);
        // 1: rename x5->3 on lane 0, lane 1 sees it, lane 0 does not
        iss(0, 5, 0, 5, 3); iss(1, 5, 6, 0, 0); ex(0, 0, 0, 0, 0); ex(1, 3, 0, 0, 0); add(1);
        // 2: rename x7->4, x9->2; lane 1 forwards from lane 0
        iss(0, 5, 9, 7, 4); iss(1, 7, 5, 9, 2); ex(0, 3, 0, 0, 0); ex(1, 4, 0, 3, 0); add(3);
        // 3: both lanes rename x4, higher lane wins with tag 5
        iss(0, 7, 9, 4, 1); iss(1, 4, 0, 4, 5); ex(0, 4, 0, 2, 0); ex(1, 1, 0, 0, 0); add(4);
        // 4: commit x7 bypass; commit x9 while lane 1 renames x9
        iss(0, 4, 7, 0, 0); iss(1, 9, 7, 9, 6);
        cmt(0, 7, 4, 32'hDEAD); cmt(1, 9, 2, 32'h11);
        ex(0, 5, 0, 0, 32'hDEAD); ex(1, 0, 32'h11, 0, 32'hDEAD); add(3);
        // 5: stale commit x4 (tag 1 vs 5), commit x12 without producer
        iss(0, 7, 9, 0, 0); iss(1, 5, 4, 0, 0);
        cmt(0, 4, 1, 32'h22); cmt(1, 12, 3, 32'hAA);
        ex(0, 0, 32'hDEAD, 6, 0); ex(1, 3, 0, 5, 0); add(3);
        // 6: two commits to x12, higher lane value wins
        iss(0, 4, 12, 0, 0); iss(1, 0, 9, 0, 0);
        cmt(0, 12, 7, 32'h1); cmt(1, 12, 7, 32'h2);
        ex(0, 5, 0, 0, 32'hAA); ex(1, 0, 0, 6, 0); add(3);
        // 7
        iss(0, 12, 0, 0, 0); iss(1, 4, 5, 0, 0); ex(0, 0, 32'h2, 0, 0); ex(1, 5, 0, 3, 0); add(3);
        // 8: flush with rdy low does nothing
        iss(0, 4, 9, 3, 7); iss(1, 3, 0, 0, 0); cmt(0, 2, 1, 32'h33);
        cur.rdy = 1'b0; cur.flush = 1'b1; cur.e.chk = 1'b0; add(3);
        // 9
        iss(0, 2, 3, 0, 0); iss(1, 4, 5, 0, 0); ex(0, 0, 0, 0, 0); ex(1, 5, 0, 3, 0); add(3);
        // 10: real flush
        iss(0, 4, 9, 3, 7); iss(1, 3, 0, 0, 0); cmt(0, 2, 1, 32'h33);
        cur.flush = 1'b1; cur.e.chk = 1'b0; add(0);
        // 11: commit survived flush, rename suppressed, stale x4 value visible
        iss(0, 2, 3, 0, 0); iss(1, 4, 9, 0, 0);
        ex(0, 0, 32'h33, 0, 0); ex(1, 0, 32'h22, 0, 32'h11); add(0);
        // 12
        iss(0, 9, 5, 10, 8); iss(1, 12, 7, 11, 9);
        ex(0, 0, 32'h11, 0, 0); ex(1, 0, 32'h2, 0, 32'hDEAD); add(2);
        // 13: rd=0 on issue and commit is ignored
        iss(0, 10, 11, 0, 5); iss(1, 0, 0, 0, 0); cmt(0, 0, 8, 32'hBAD);
        ex(0, 8, 0, 9, 0); ex(1, 0, 0, 0, 0); add(2);

        v = '0;
        v.rdy = 1'b1;
        drive(v);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1 check("reset busy_count", 32'(busy_count), 32'd0);

        for (int n = 0; n < tbl.size(); n++) begin
            v = tbl[n];
            @(negedge clk);
            drive(v);
            sb.push_back(v.e);
            #2;
            e = sb.pop_front();
            if (e.chk) begin
                for (int l = 0; l < 2; l++) begin
                    check($sformatf("v%0d l%0d qj", n, l), 32'(qj_to_issuer[l*4 +: 4]), 32'(e.qj[l]));
                    check($sformatf("v%0d l%0d vj", n, l), vj_to_issuer[l*32 +: 32], e.vj[l]);
                    check($sformatf("v%0d l%0d qk", n, l), 32'(qk_to_issuer[l*4 +: 4]), 32'(e.qk[l]));
                    check($sformatf("v%0d l%0d vk", n, l), vk_to_issuer[l*32 +: 32], e.vk[l]);
                end
            end
            @(posedge clk);
            #1 check($sformatf("v%0d busy_count", n), 32'(busy_count), 32'(e.busy));
        end

        // Asynchronous reset between edges clears outputs immediately
        @(negedge clk);
        v = '0;
        v.rdy = 1'b1;
        v.rs = {5'd7, 5'd10};
        v.rt = {5'd12, 5'd11};
        drive(v);
        #1 check("pre-rst qj0", 32'(qj_to_issuer[3:0]), 32'd8);
        #1 rst = 1'b1;
        #1;
        check("rst qj", 32'(qj_to_issuer), 32'd0);
        check("rst qk", 32'(qk_to_issuer), 32'd0);
        check("rst vj lane1", vj_to_issuer[63:32], 32'd0);
        check("rst vk lane1", vk_to_issuer[63:32], 32'd0);
        check("rst busy_count", 32'(busy_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post-rst vj lane1", vj_to_issuer[63:32], 32'd0);
        check("post-rst qj lane0", 32'(qj_to_issuer[3:0]), 32'd0);
        check("post-rst busy_count", 32'(busy_count), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
